// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable, glitch-free CPU clock divider with free-run and single-step.
// Define CLK_DIV_SIM_EN to reset the half-period registers to DIV_SIM instead of DIV_DEFAULT.
module clk_div_ctrl #(
    parameter int               CNT_W       = 25,
    parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(25'h1FAF080),
    parameter logic [CNT_W-1:0] DIV_SIM     = CNT_W'(4)
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    input  logic             run_en,
    input  logic             step_req,
    output logic             step_ack,
    output logic             clk,
    output logic             clk_rise,
    output logic             clk_fall,
    output logic             busy
);

`ifdef CLK_DIV_SIM_EN
    localparam bit SIM_EN = 1'b1;
`else
    localparam bit SIM_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] DIV_RST = SIM_EN ? DIV_SIM : DIV_DEFAULT;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PARK,
        STEP_HI,
        STEP_LO
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] count, count_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] shadow;
    logic             clk_d, rise_d, fall_d, ack_d;
    logic             tog;

    assign tog  = (count == half_q);
    assign busy = (state != IDLE);

    always_comb begin
        state_d = state;
        count_d = '0;
        half_d  = half_q;
        clk_d   = clk;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        ack_d   = 1'b0;
        unique case (state)
            IDLE: begin
                clk_d = 1'b0;
                if (run_en || step_req) begin
                    state_d = run_en ? RUN : STEP_HI;
                    clk_d   = 1'b1;
                    rise_d  = 1'b1;
                    half_d  = shadow;
                end
            end
            RUN: begin
                count_d = count + 1'b1;
                if (tog) begin
                    count_d = '0;
                    half_d  = shadow;
                    if (clk) begin
                        clk_d  = 1'b0;
                        fall_d = 1'b1;
                    end else if (run_en) begin
                        clk_d  = 1'b1;
                        rise_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (clk && !run_en) begin
                    state_d = PARK;
                end
            end
            PARK, STEP_HI: begin
                count_d = count + 1'b1;
                if (tog) begin
                    count_d = '0;
                    half_d  = shadow;
                    clk_d   = 1'b0;
                    fall_d  = 1'b1;
                    state_d = (state == PARK) ? IDLE : STEP_LO;
                end
            end
            STEP_LO: begin
                count_d = count + 1'b1;
                if (tog) begin
                    count_d = '0;
                    half_d  = shadow;
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                clk_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            half_q   <= DIV_RST;
            clk      <= 1'b0;
            clk_rise <= 1'b0;
            clk_fall <= 1'b0;
            step_ack <= 1'b0;
        end else begin
            state    <= state_d;
            count    <= count_d;
            half_q   <= half_d;
            clk      <= clk_d;
            clk_rise <= rise_d;
            clk_fall <= fall_d;
            step_ack <= ack_d;
        end
    end

    // Shadow only feeds half_q at toggle events, so loads never cut a half short.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= DIV_RST;
        end else if (div_load) begin
            shadow <= div_val;
        end
    end

endmodule
